// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// FSM state encoding and mux select constants.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } arb_state_e;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux2_1_bus.sv
// DATA_W-wide 2:1 bus multiplexer; sel picks in1 (SEL_IN1) or in2 (SEL_IN2).
module mux2_1_bus
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              sel,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = (sel == SEL_IN2) ? in2 : in1;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one muxed valid/ready channel between two requesters,
// with a per-grant burst limit of MAX_BURST beats.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  output logic              in2_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int unsigned       CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  arb_state_e       state, state_nxt;
  logic             sel_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             xfer;
  logic             rel_grant;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      sel        <= SEL_IN1;
      last_grant <= SEL_IN2;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    out_valid      = 1'b0;
    in1_ready      = 1'b0;
    in2_ready      = 1'b0;
    xfer           = 1'b0;
    rel_grant      = 1'b0;

    unique case (state)
      IDLE: begin
        if (in1_valid && (!in2_valid || last_grant == SEL_IN2)) begin
          state_nxt = GNT1;
          sel_nxt   = SEL_IN1;
        end else if (in2_valid) begin
          state_nxt = GNT2;
          sel_nxt   = SEL_IN2;
        end
      end

      GNT1: begin
        out_valid = in1_valid;
        in1_ready = out_ready;
        xfer      = in1_valid && out_ready;
        rel_grant = !in1_valid || (xfer && beat_cnt == LAST_BEAT);
        if (rel_grant) begin
          last_grant_nxt = SEL_IN1;
          beat_cnt_nxt   = '0;
          // Hand straight over to the other requester when it is waiting.
          if (in2_valid) begin
            state_nxt = GNT2;
            sel_nxt   = SEL_IN2;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_ONE;
        end
      end

      GNT2: begin
        out_valid = in2_valid;
        in2_ready = out_ready;
        xfer      = in2_valid && out_ready;
        rel_grant = !in2_valid || (xfer && beat_cnt == LAST_BEAT);
        if (rel_grant) begin
          last_grant_nxt = SEL_IN2;
          beat_cnt_nxt   = '0;
          if (in1_valid) begin
            state_nxt = GNT1;
            sel_nxt   = SEL_IN1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // While reset is asserted nothing is handshaken, so a partial burst is dropped cleanly.
    if (!sys_rst_n) begin
      out_valid = 1'b0;
      in1_ready = 1'b0;
      in2_ready = 1'b0;
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  mux2_1_bus #(
    .DATA_W(DATA_W)
  ) u_mux (
    .in1(in1_data),
    .in2(in2_data),
    .sel(sel),
    .out(out_data)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: queue-driven requesters, a beat scoreboard,
// and a second instance with MAX_BURST=1 for the strict-alternation case.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       in1_valid, in2_valid, in1_ready, in2_ready;
  logic [7:0] in1_data, in2_data, out_data;
  logic       out_valid, out_ready, sel, busy;

  logic       b_in1_valid, b_in2_valid, b_in1_ready, b_in2_ready;
  logic [7:0] b_in1_data, b_in2_data, b_out_data;
  logic       b_out_valid, b_out_ready, b_sel, b_busy;

  logic [7:0] src1_q[$];
  logic [7:0] src2_q[$];
  logic [8:0] exp_q[$];
  logic       pend1 = 1'b0;
  logic       pend2 = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_dut_b1 (
    .sys_clk(clk), .sys_rst_n(sys_rst_n),
    .in1_valid(b_in1_valid), .in1_data(b_in1_data), .in1_ready(b_in1_ready),
    .in2_valid(b_in2_valid), .in2_data(b_in2_data), .in2_ready(b_in2_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .sel(b_sel), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester models and scoreboard: drive at negedge+1, sample at negedge+2.
  always @(negedge clk) begin
    logic [7:0] tmp;
    logic [8:0] e;
    if (pend1) tmp = src1_q.pop_front();
    if (pend2) tmp = src2_q.pop_front();
    #1;
    in1_valid = (src1_q.size() != 0);
    in1_data  = (src1_q.size() != 0) ? src1_q[0] : 8'h00;
    in2_valid = (src2_q.size() != 0);
    in2_data  = (src2_q.size() != 0) ? src2_q[0] : 8'h00;
    #1;
    pend1 = in1_valid && in1_ready && sys_rst_n;
    pend2 = in2_valid && in2_ready && sys_rst_n;
    if (sys_rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {24'h0, out_data}, {24'h0, e[7:0]});
        chk("sb_sel", {31'h0, sel}, {31'h0, e[8]});
        chk("sb_rdy_granted", {31'h0, (e[8] ? in2_ready : in1_ready)}, 32'd1);
        chk("sb_rdy_other", {31'h0, (e[8] ? in1_ready : in2_ready)}, 32'd0);
      end
    end
  end

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || src1_q.size() != 0 || src2_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk); #3;
      n++;
    end
    chk(tag, {31'h0, (n < 60)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c1;
    int unsigned c2;
    logic        es;
    sys_rst_n   = 1'b0;
    out_ready   = 1'b0;
    b_in1_valid = 1'b0; b_in2_valid = 1'b0; b_out_ready = 1'b0;
    b_in1_data  = 8'h00; b_in2_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_sel", {31'h0, sel}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_in1_ready", {31'h0, in1_ready}, 32'd0);
    chk("rst_in2_ready", {31'h0, in2_ready}, 32'd0);
    chk("rst_b1_busy", {31'h0, b_busy}, 32'd0);

    // 1: single beat from in1, one cycle of grant latency
    @(negedge clk);
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    src1_q.push_back(8'hA5);
    exp_q.push_back({1'b0, 8'hA5});
    #3;
    chk("t1_latency_valid", {31'h0, out_valid}, 32'd0);
    chk("t1_latency_busy", {31'h0, busy}, 32'd0);
    @(negedge clk); #3;
    chk("t1_sel", {31'h0, sel}, 32'd0);
    chk("t1_out_valid", {31'h0, out_valid}, 32'd1);
    chk("t1_out_data", {24'h0, out_data}, 32'h0000_00A5);
    chk("t1_in1_ready", {31'h0, in1_ready}, 32'd1);
    chk("t1_busy", {31'h0, busy}, 32'd1);
    wait_idle("t1_drain");

    // 2: both requesters loaded from reset, bursts of 4 with no idle gap
    @(negedge clk); sys_rst_n = 1'b0;
    @(negedge clk); sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) src1_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) src2_q.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h20 + 8'(i)});
    for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #3;
      chk("t2_continuous_valid", {31'h0, out_valid}, 32'd1);
      chk("t2_sel", {31'h0, sel}, (i >= 4 && i < 8) ? 32'd1 : 32'd0);
    end
    wait_idle("t2_drain");

    // 3: stall during GNT1, then the burst completes after 4 beats total
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src1_q.push_back(8'h30 + 8'(i));
      exp_q.push_back({1'b0, 8'h30 + 8'(i)});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      chk("t3_stall_valid", {31'h0, out_valid}, 32'd1);
      chk("t3_stall_data", {24'h0, out_data}, 32'h0000_0030);
      chk("t3_stall_in1_ready", {31'h0, in1_ready}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #3;
      chk("t3_resume_data", {24'h0, out_data}, 32'h30 + 32'(i));
      chk("t3_resume_ready", {31'h0, in1_ready}, 32'd1);
    end
    @(negedge clk); #3;
    chk("t3_burst_end_busy", {31'h0, busy}, 32'd0);
    wait_idle("t3_drain");

    // 4: GNT2 loses valid after two beats with in1 idle -> IDLE, sel held at 1
    @(negedge clk);
    src2_q.push_back(8'h40); src2_q.push_back(8'h41);
    exp_q.push_back({1'b1, 8'h40}); exp_q.push_back({1'b1, 8'h41});
    @(negedge clk); #3;
    chk("t4_sel", {31'h0, sel}, 32'd1);
    @(negedge clk); #3;
    chk("t4_beat2_data", {24'h0, out_data}, 32'h0000_0041);
    @(negedge clk); #3;
    chk("t4_drop_valid", {31'h0, out_valid}, 32'd0);
    chk("t4_drop_busy", {31'h0, busy}, 32'd1);
    @(negedge clk); #3;
    chk("t4_idle_busy", {31'h0, busy}, 32'd0);
    chk("t4_idle_valid", {31'h0, out_valid}, 32'd0);
    chk("t4_idle_sel", {31'h0, sel}, 32'd1);
    wait_idle("t4_drain");

    // 5: reset during beat 3 of a GNT2 burst, then in1 wins the tie
    @(negedge clk);
    for (int i = 0; i < 4; i++) src2_q.push_back(8'h50 + 8'(i));
    exp_q.push_back({1'b1, 8'h50}); exp_q.push_back({1'b1, 8'h51});
    @(negedge clk); #3;
    chk("t5_sel", {31'h0, sel}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    sys_rst_n = 1'b0;
    #3;
    chk("t5_rst_cycle_in2_ready", {31'h0, in2_ready}, 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    src1_q.push_back(8'h60);
    exp_q.push_back({1'b0, 8'h60});
    exp_q.push_back({1'b1, 8'h52});
    exp_q.push_back({1'b1, 8'h53});
    #3;
    chk("t5_after_rst_busy", {31'h0, busy}, 32'd0);
    chk("t5_after_rst_sel", {31'h0, sel}, 32'd0);
    chk("t5_after_rst_valid", {31'h0, out_valid}, 32'd0);
    @(negedge clk); #3;
    chk("t5_tie_sel", {31'h0, sel}, 32'd0);
    chk("t5_tie_data", {24'h0, out_data}, 32'h0000_0060);
    chk("t5_tie_in1_ready", {31'h0, in1_ready}, 32'd1);
    wait_idle("t5_drain");

    // 6: MAX_BURST=1 instance, both loaded -> strict alternation starting with in1
    @(negedge clk);
    c1 = 0; c2 = 0;
    b_in1_valid = 1'b1; b_in2_valid = 1'b1; b_out_ready = 1'b1;
    b_in1_data = 8'h80; b_in2_data = 8'hC0;
    #3;
    chk("t6_idle_first", {31'h0, b_busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_in1_data = 8'h80 + 8'(c1);
      b_in2_data = 8'hC0 + 8'(c2);
      #3;
      es = (i % 2 == 1);
      chk("t6_sel", {31'h0, b_sel}, {31'h0, es});
      chk("t6_valid", {31'h0, b_out_valid}, 32'd1);
      chk("t6_data", {24'h0, b_out_data}, es ? 32'hC0 + c2 : 32'h80 + c1);
      chk("t6_in1_ready", {31'h0, b_in1_ready}, {31'h0, ~es});
      chk("t6_in2_ready", {31'h0, b_in2_ready}, {31'h0, es});
      if (es) c2++; else c1++;
    end
    chk("t6_beats_in1", c1, 32'd4);
    chk("t6_beats_in2", c2, 32'd4);
    b_in1_valid = 1'b0; b_in2_valid = 1'b0;

    @(negedge clk);
    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
